// File: rtl/fpnew_pkg.sv
// Shared FPnew types and format helpers: format encodings, operation and rounding enums,
// and the canonical quiet-NaN generator used by every unit that NaN-boxes operands.
package fpnew_pkg;

  localparam int unsigned NUM_FP_FORMATS = 5;
  localparam int unsigned FP_MAX_WIDTH   = 64;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef logic [0:NUM_FP_FORMATS-1] fmt_logic_t;

  function automatic int unsigned exp_bits(input fp_format_e fmt);
    case (fmt)
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(input fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(input fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

  function automatic int unsigned max_fp_width(input fmt_logic_t cfg);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < NUM_FP_FORMATS; i++) begin
      if (cfg[i] && fp_width(fp_format_e'(i)) > res) res = fp_width(fp_format_e'(i));
    end
    return res;
  endfunction

  // Positive quiet NaN of fmt, NaN-boxed: every bit above the format's width is 1.
  function automatic logic [FP_MAX_WIDTH-1:0] canonical_qnan(input fp_format_e fmt);
    logic [FP_MAX_WIDTH-1:0] res;
    int unsigned w;
    int unsigned m;
    w   = fp_width(fmt);
    m   = man_bits(fmt);
    res = '1;
    for (int unsigned i = 0; i < FP_MAX_WIDTH; i++) begin
      if (i == w - 1 || i + 1 < m) res[i] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fpnew_nanbox_sanitize.sv
// Replaces an operand that is not correctly NaN-boxed for the destination format
// with that format's canonical quiet NaN.
module fpnew_nanbox_sanitize
  import fpnew_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] operand,
  input  logic             is_boxed,
  input  fp_format_e       fmt,
  output logic [WIDTH-1:0] sanitized
);

  logic [FP_MAX_WIDTH-1:0] qnan;

  assign qnan      = canonical_qnan(fmt);
  assign sanitized = is_boxed ? operand : qnan[WIDTH-1:0];

endmodule

// File: rtl/fpnew_divsqrt_issue_q.sv
// Small issue queue in front of the div/sqrt wrapper: sanitises operands on push and
// presents the oldest entry from a circular buffer of any depth 1..8.
module fpnew_divsqrt_issue_q
  import fpnew_pkg::*;
#(
  parameter fmt_logic_t  FpFmtConfig = '1,
  parameter int unsigned Depth       = 2,
  parameter type         TagType     = logic,
  parameter type         AuxType     = logic,
  localparam int unsigned WIDTH      = max_fp_width(FpFmtConfig)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [1:0][WIDTH-1:0]                  operands_i,
  input  logic [NUM_FP_FORMATS-1:0][1:0]         is_boxed_i,
  input  roundmode_e                             rnd_mode_i,
  input  operation_e                             op_i,
  input  fp_format_e                             dst_fmt_i,
  input  TagType                                 tag_i,
  input  AuxType                                 aux_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic                                   flush_i,
  output logic [1:0][WIDTH-1:0]                  operands_o,
  output roundmode_e                             rnd_mode_o,
  output operation_e                             op_o,
  output fp_format_e                             dst_fmt_o,
  output TagType                                 tag_o,
  output AuxType                                 aux_o,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [$clog2(Depth+1)-1:0]             count_o,
  output logic                                   busy_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic [1:0][WIDTH-1:0] operands;
    roundmode_e            rnd_mode;
    operation_e            op;
    fp_format_e            dst_fmt;
    TagType                tag;
    AuxType                aux;
  } entry_t;

  entry_t                mem [Depth];
  entry_t                wdata;
  entry_t                head;
  logic [1:0][WIDTH-1:0] clean_ops;
  logic [PtrW-1:0]       rd_ptr;
  logic [PtrW-1:0]       wr_ptr;
  logic [CntW-1:0]       count;
  logic                  push;
  logic                  pop;

  for (genvar k = 0; k < 2; k++) begin : g_sanitize
    fpnew_nanbox_sanitize #(
      .WIDTH (WIDTH)
    ) u_sanitize (
      .operand   (operands_i[k]),
      .is_boxed  (is_boxed_i[dst_fmt_i][k]),
      .fmt       (dst_fmt_i),
      .sanitized (clean_ops[k])
    );
  end

  assign wdata = '{operands: clean_ops, rnd_mode: rnd_mode_i, op: op_i,
                   dst_fmt: dst_fmt_i, tag: tag_i, aux: aux_i};

  // Handshakes depend only on count and flush, never on out_ready_i.
  assign in_ready_o  = (count != CntW'(Depth)) & ~flush_i;
  assign out_valid_o = (count != '0) & ~flush_i;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: state registers use <= so every flop samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // NOTE: storage has no reset; count gates validity, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head       = mem[rd_ptr];
  assign operands_o = head.operands;
  assign rnd_mode_o = head.rnd_mode;
  assign op_o       = head.op;
  assign dst_fmt_o  = head.dst_fmt;
  assign tag_o      = head.tag;
  assign aux_o      = head.aux;
  assign count_o    = count;
  assign busy_o     = (count != '0);

endmodule

// File: tb/tb_fpnew_divsqrt_issue_q.sv
// Drives a Depth=2 and a Depth=3 queue from shared stimulus and compares both against
// queue-based reference models.
module tb_fpnew_divsqrt_issue_q;
  import fpnew_pkg::*;

  typedef logic [7:0] tag_t;

  typedef struct {
    logic [1:0][63:0] ops;
    logic [2:0]       rm;
    logic [3:0]       op;
    logic [2:0]       fmt;
    logic [7:0]       tag;
    logic             aux;
  } ent_t;

  logic                          clk;
  logic                          rst_n;
  logic                          in_valid;
  logic                          out_ready;
  logic                          flush;
  logic [1:0][63:0]              operands;
  logic [NUM_FP_FORMATS-1:0][1:0] is_boxed;
  roundmode_e                    rnd_mode;
  operation_e                    op;
  fp_format_e                    dst_fmt;
  tag_t                          tag;
  logic                          aux;

  logic             in_ready  [2];
  logic             out_valid [2];
  logic             busy      [2];
  logic [1:0][63:0] ops_o     [2];
  roundmode_e       rm_o      [2];
  operation_e       op_o      [2];
  fp_format_e       fmt_o     [2];
  tag_t             tag_o     [2];
  logic             aux_o     [2];
  logic [1:0]       cnt_o     [2];

  ent_t mq [2][$];
  int   n_vec  = 0;
  int   n_fail = 0;

  fpnew_divsqrt_issue_q #(.Depth(2), .TagType(tag_t)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(operands), .is_boxed_i(is_boxed),
    .rnd_mode_i(rnd_mode), .op_i(op), .dst_fmt_i(dst_fmt), .tag_i(tag), .aux_i(aux),
    .in_valid_i(in_valid), .in_ready_o(in_ready[0]), .flush_i(flush),
    .operands_o(ops_o[0]), .rnd_mode_o(rm_o[0]), .op_o(op_o[0]), .dst_fmt_o(fmt_o[0]),
    .tag_o(tag_o[0]), .aux_o(aux_o[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
    .count_o(cnt_o[0]), .busy_o(busy[0])
  );

  fpnew_divsqrt_issue_q #(.Depth(3), .TagType(tag_t)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(operands), .is_boxed_i(is_boxed),
    .rnd_mode_i(rnd_mode), .op_i(op), .dst_fmt_i(dst_fmt), .tag_i(tag), .aux_i(aux),
    .in_valid_i(in_valid), .in_ready_o(in_ready[1]), .flush_i(flush),
    .operands_o(ops_o[1]), .rnd_mode_o(rm_o[1]), .op_o(op_o[1]), .dst_fmt_o(fmt_o[1]),
    .tag_o(tag_o[1]), .aux_o(aux_o[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
    .count_o(cnt_o[1]), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Canonical quiet NaNs, NaN-boxed to 64 bits.
  function automatic logic [63:0] qnan_of(input logic [2:0] f);
    case (f)
      3'd1:    return 64'h7FF80000_00000000;
      3'd2:    return 64'hFFFFFFFF_FFFF7E00;
      3'd3:    return 64'hFFFFFFFF_FFFFFF7E;
      3'd4:    return 64'hFFFFFFFF_FFFF7FC0;
      default: return 64'hFFFFFFFF_7FC00000;
    endcase
  endfunction

  function automatic ent_t incoming();
    ent_t e;
    for (int k = 0; k < 2; k++)
      e.ops[k] = is_boxed[dst_fmt][k] ? operands[k] : qnan_of(dst_fmt);
    e.rm  = rnd_mode;
    e.op  = op;
    e.fmt = dst_fmt;
    e.tag = tag;
    e.aux = aux;
    return e;
  endfunction

  // One clock: compare at the falling edge, then advance the models at the rising edge.
  task automatic step();
    bit   exp_rdy [2];
    bit   exp_vld [2];
    ent_t e;
    string p;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      p = $sformatf("d%0d", dep(i));
      exp_rdy[i] = (mq[i].size() < dep(i)) && !flush;
      exp_vld[i] = (mq[i].size() > 0) && !flush;
      check({p, ".in_ready"},  64'(in_ready[i]),  64'(exp_rdy[i]));
      check({p, ".out_valid"}, 64'(out_valid[i]), 64'(exp_vld[i]));
      check({p, ".count"},     64'(cnt_o[i]),     64'(mq[i].size()));
      check({p, ".busy"},      64'(busy[i]),      64'(mq[i].size() != 0));
      if (exp_vld[i]) begin
        e = mq[i][0];
        check({p, ".op0"}, ops_o[i][0], e.ops[0]);
        check({p, ".op1"}, ops_o[i][1], e.ops[1]);
        check({p, ".meta"}, 64'({rm_o[i], op_o[i], fmt_o[i], tag_o[i], aux_o[i]}),
              64'({e.rm, e.op, e.fmt, e.tag, e.aux}));
      end
    end
    @(posedge clk);
    e = incoming();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || flush) mq[i].delete();
      else begin
        if (exp_vld[i] && out_ready) void'(mq[i].pop_front());
        if (in_valid && exp_rdy[i]) mq[i].push_back(e);
      end
    end
    #1;
  endtask

  task automatic set_op(input logic [63:0] o0, input logic [63:0] o1, input tag_t t);
    operands[0] = o0;
    operands[1] = o1;
    tag         = t;
    rnd_mode    = RNE;
    op          = DIV;
    dst_fmt     = FP32;
    aux         = t[0];
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    is_boxed = '1; set_op('0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    step();                       // still in reset: empty, ready
    rst_n = 1'b1;
    step();

    // Boxed FP32 pass-through, drained immediately
    out_ready = 1'b1; in_valid = 1'b1;
    set_op(64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_40000000, 8'd1);
    step();
    in_valid = 1'b0;
    step();
    step();

    // Operand 1 not boxed for FP32 -> canonical NaN, operand 0 untouched
    is_boxed[FP32][1] = 1'b0; in_valid = 1'b1;
    set_op(64'hFFFFFFFF_3F800000, 64'h00000000_40000000, 8'd2);
    step();
    in_valid = 1'b0; is_boxed = '1;
    check("nanbox.op1", ops_o[0][1], 64'hFFFFFFFF_7FC00000);
    check("nanbox.op0", ops_o[0][0], 64'hFFFFFFFF_3F800000);
    step();

    // Fill with the consumer stalled, then release it
    out_ready = 1'b0; in_valid = 1'b1;
    for (int t = 10; t < 14; t++) begin
      set_op({32'hFFFFFFFF, 32'(t)}, 64'hFFFFFFFF_3F800000, 8'(t));
      step();
    end
    out_ready = 1'b1;
    for (int t = 14; t < 17; t++) begin
      set_op({32'hFFFFFFFF, 32'(t)}, 64'hFFFFFFFF_3F800000, 8'(t));
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Continuous push and pop across pointer wrap
    in_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      set_op({32'hFFFFFFFF, 32'(t * 7)}, {32'hFFFFFFFF, 32'(t)}, 8'(t));
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Flush with a concurrent push while holding two entries
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(64'hFFFFFFFF_11111111, 64'hFFFFFFFF_22222222, 8'd20); step();
    set_op(64'hFFFFFFFF_33333333, 64'hFFFFFFFF_44444444, 8'd21); step();
    flush = 1'b1; out_ready = 1'b1;
    set_op(64'hFFFFFFFF_55555555, 64'hFFFFFFFF_66666666, 8'd22); step();
    flush = 1'b0; in_valid = 1'b0;
    step();

    // Reset while one entry is queued
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(64'hFFFFFFFF_77777777, 64'hFFFFFFFF_88888888, 8'd30); step();
    rst_n = 1'b0; out_ready = 1'b1; step();
    rst_n = 1'b1; in_valid = 1'b0; step();

    // Randomised traffic, all formats and operations
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      rst_n     = ($urandom_range(0, 99) != 0);
      operands[0] = {$urandom, $urandom};
      operands[1] = {$urandom, $urandom};
      is_boxed  = 10'($urandom);
      rnd_mode  = roundmode_e'($urandom_range(0, 4));
      op        = operation_e'($urandom_range(0, 14));
      dst_fmt   = fp_format_e'($urandom_range(0, 4));
      tag       = 8'($urandom);
      aux       = 1'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fpnew_divsqrt_issue_q.md
FPNEW_DIVSQRT_ISSUE_Q -- requirements
Module: fpnew_divsqrt_issue_q

Interface
REQ-001 The block SHALL have parameter FpFmtConfig, default '1, selecting the enabled FP formats; localparam WIDTH = fpnew_pkg::max_fp_width(FpFmtConfig).
REQ-002 The block SHALL have parameter Depth, default 2, giving the number of queue entries, legal range 1..8.
REQ-003 The block SHALL have parameters TagType and AuxType, default logic, giving the sideband types carried per entry.
REQ-004 The block SHALL have port clk_i, input, width 1: the single clock, rising edge.
REQ-005 The block SHALL have port rst_ni, input, width 1: reset, synchronous and active-low.
REQ-006 The block SHALL have port operands_i, input, [1:0][WIDTH-1:0]: the two operands.
REQ-007 The block SHALL have port is_boxed_i, input, [NUM_FP_FORMATS-1:0][1:0]: per-format, per-operand NaN-box valid flags.
REQ-008 The block SHALL have ports rnd_mode_i, op_i, dst_fmt_i, tag_i and aux_i as inputs typed fpnew_pkg::roundmode_e, operation_e, fp_format_e, TagType and AuxType respectively.
REQ-009 The block SHALL have the input handshake in_valid_i (input, 1) and in_ready_o (output, 1).
REQ-010 The block SHALL have port flush_i, input, width 1: discard all queued operations.
REQ-011 The block SHALL have outputs operands_o, rnd_mode_o, op_o, dst_fmt_o, tag_o and aux_o, typed as the matching inputs, presenting the head entry.
REQ-012 The block SHALL have the output handshake out_valid_o (output, 1) and out_ready_i (input, 1), driving the divsqrt wrapper input.
REQ-013 The block SHALL have port count_o, output, $clog2(Depth+1) bits: the number of occupied entries.
REQ-014 The block SHALL have port busy_o, output, width 1: high while count is nonzero.

Function
REQ-015 The block SHALL sanitise each operand at push time: if is_boxed_i[dst_fmt_i][k] is 0, operand k is stored as the canonical quiet NaN of dst_fmt_i, with all bits above that format's width set to 1.
REQ-016 Boxed operands SHALL be stored unmodified, and op_i SHALL be stored unmodified even when it is neither DIV nor SQRT.
REQ-017 The queue SHALL be a circular buffer with a read pointer, a write pointer and a count; each pointer SHALL wrap from Depth-1 to 0, and Depth is not required to be a power of two.
REQ-018 in_ready_o SHALL equal (count != Depth) & ~flush_i, with no combinational path from out_ready_i.
REQ-019 A push SHALL occur when in_valid_i & in_ready_o.
REQ-020 A pop SHALL occur when out_valid_o & out_ready_i & ~flush_i.
REQ-021 out_valid_o SHALL equal (count != 0) & ~flush_i.
REQ-022 Output ports SHALL be driven from the entry at the read pointer, with no bypass path: minimum latency from push to out_valid_o is 1 cycle.
REQ-023 On a simultaneous push and pop the count SHALL be unchanged and both pointers SHALL advance; this is legal at any nonzero count below Depth.
REQ-024 When full, a pop SHALL free one entry that becomes writable in the following cycle.
REQ-025 out_valid_o and all output payload SHALL stay stable while out_valid_o & ~out_ready_i.
REQ-026 flush_i SHALL set count and both pointers to 0 at the next edge, and the push and pop of that cycle SHALL be suppressed.
REQ-027 count_o SHALL be exact every cycle; busy_o SHALL equal count_o != 0.

Reset
REQ-028 When rst_ni is 0 at a clock edge, count, both pointers, out_valid_o, busy_o and count_o SHALL be 0 after that edge, and in_ready_o SHALL be 1 once rst_ni is released.
REQ-029 Entry storage SHALL NOT be reset; payload outputs are don't-care while out_valid_o is 0.
REQ-030 A reset asserted mid-operation SHALL discard all entries exactly like flush_i, with no partial pop.

Structure
REQ-031 The canonical-NaN-per-format function SHALL reside in fpnew_pkg and be shared with the other fpnew units.
REQ-032 The operand sanitiser SHALL be one combinational sub-module, fpnew_nanbox_sanitize, instantiated once per operand.
REQ-033 Queue control (pointers, count, handshakes) SHALL be local to this block.

Verification
REQ-034 Scenario: FP32, operands 0xFFFFFFFF_3F800000 and 0xFFFFFFFF_40000000, both boxed, out_ready_i=1 -> identical operands on the output 1 cycle after the push, count_o back to 0.
REQ-035 Scenario: FP32, is_boxed_i[FP32][1]=0, operand1=0x00000000_40000000 -> operand1 out = 0xFFFFFFFF_7FC00000, operand0 untouched.
REQ-036 Scenario: Depth=2, out_ready_i=0, three pushes attempted -> in_ready_o=0 after 2 pushes, count_o=2, the third op is accepted 1 cycle after the first pop.
REQ-037 Scenario: Depth=3, continuous push and pop for 10 ops with tags 0..9 -> tags emerge in order 0..9 across pointer wrap, and count_o stays constant during overlap.
REQ-038 Scenario: count_o=2 with flush_i pulsed together with in_valid_i=1 -> count_o=0 next cycle, no pop, the concurrent op is dropped.
REQ-039 Scenario: rst_ni=0 asserted while count_o=1 -> out_valid_o=0 and count_o=0 after the edge, in_ready_o=1 once rst_ni is released.
